// File: rtl/funct_generator_lut_reader.sv
// rtl/funct_generator_lut_reader.sv - phase-accumulator LUT reader with 2-deep output buffer and valid/ready delivery
module funct_generator_lut_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [PHASE_WIDTH-1:0] freq_step_i,
  output logic [ADDR_WIDTH-1:0]  read_addr_o,
  input  logic [DATA_WIDTH-1:0]  read_data_i,
  output logic [DATA_WIDTH-1:0]  sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic                   wrap_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [DATA_WIDTH-1:0]  out_q;
  logic [DATA_WIDTH-1:0]  skid_q;
  logic                   out_valid_q;
  logic                   skid_valid_q;
  logic                   pend_q;
  logic                   wrap_q;

  logic                   pop;
  logic [2:0]             load;
  logic                   issue;
  logic [PHASE_WIDTH:0]   phase_sum;

  logic [DATA_WIDTH-1:0]  out_n;
  logic [DATA_WIDTH-1:0]  skid_n;
  logic                   out_valid_n;
  logic                   skid_valid_n;

  assign pop       = out_valid_q & sample_ready_i;
  // Entries that will be held after this cycle's capture and pop; a new read fits only below 2.
  assign load      = {2'b00, out_valid_q} + {2'b00, skid_valid_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue     = en_i & ~clear_i & (load < 3'd2);
  assign phase_sum = {1'b0, phase_q} + {1'b0, freq_step_i};

  always_comb begin
    out_n        = out_q;
    skid_n       = skid_q;
    out_valid_n  = out_valid_q;
    skid_valid_n = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_n        = skid_q;
        skid_valid_n = 1'b0;
      end else begin
        out_valid_n  = 1'b0;
      end
    end
    // Returning LUT data lands behind whatever is still held, keeping order.
    if (pend_q) begin
      if (!out_valid_n) begin
        out_n        = read_data_i;
        out_valid_n  = 1'b1;
      end else begin
        skid_n       = read_data_i;
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase_q      <= '0;
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else if (clear_i) begin
      state        <= IDLE;
      phase_q      <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      if (issue) begin
        phase_q <= phase_sum[PHASE_WIDTH-1:0];
      end
      pend_q       <= issue;
      wrap_q       <= issue & phase_sum[PHASE_WIDTH];
      out_q        <= out_n;
      skid_q       <= skid_n;
      out_valid_q  <= out_valid_n;
      skid_valid_q <= skid_valid_n;
      case (state)
        IDLE: begin
          if (en_i) state <= RUN;
        end
        RUN: begin
          if (!en_i) state <= (out_valid_n | skid_valid_n) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (en_i) state <= RUN;
          else if (!out_valid_n && !skid_valid_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read_addr_o    = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign sample_o       = out_q;
  assign sample_valid_o = out_valid_q;
  assign wrap_o         = wrap_q;
  assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_funct_generator_lut_reader.sv
// tb/tb_funct_generator_lut_reader.sv - randomized scoreboard bench for funct_generator_lut_reader
module tb_funct_generator_lut_reader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic          ready = 1'b0;
  logic [PW-1:0] step = '0;
  logic [DW-1:0] read_data = '0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] sample;
  logic          valid;
  logic          wrap;
  logic          busy;

  funct_generator_lut_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PHASE_WIDTH(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en),
    .clear_i        (clear),
    .freq_step_i    (step),
    .read_addr_o    (read_addr),
    .read_data_i    (read_data),
    .sample_o       (sample),
    .sample_valid_o (valid),
    .sample_ready_i (ready),
    .wrap_o         (wrap),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] lut [0:255];
  always @(posedge clk) read_data <= lut[read_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the n-th delivered sample after a restart is LUT[phase_n >> 8], phase advancing by step per sample.
  logic [PW-1:0] exp_phase = '0;
  int            xfers = 0;
  int            dut_wraps = 0;
  int            exp_wraps = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (rst || clear) begin
      exp_phase  = '0;
      dut_wraps  = 0;
      exp_wraps  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_eq("stable", {15'd0, valid, sample}, {15'd0, 1'b1, stall_data});
      if (valid && ready) begin
        check_eq("sample", {16'd0, sample}, {16'd0, lut[exp_phase[15:8]]});
        if ({1'b0, exp_phase} + {1'b0, step} > 17'h0FFFF) exp_wraps++;
        exp_phase = exp_phase + step;
        xfers++;
      end
      if (wrap) dut_wraps++;
      stall_prev = valid & ~ready;
      stall_data = sample;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
  endtask

  task automatic drain_check();
    en = 1'b0;
    clear = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 50 && busy; i++) next_cycle();
    repeat (2) next_cycle();
    check_eq("drain_busy", {31'd0, busy}, 32'd0);
    check_eq("drain_valid", {31'd0, valid}, 32'd0);
    check_eq("wrap_count", dut_wraps, exp_wraps);
  endtask

  int            base;
  logic [AW-1:0] addr_hold;

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = DW'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_addr", {24'd0, read_addr}, 32'd0);
    check_eq("rst_sample", {16'd0, sample}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_wrap", {31'd0, wrap}, 32'd0);

    // Ramp: one address per cycle, first valid two cycles after the first issue
    step = 16'h0100;
    ready = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_eq("ramp_addr", {24'd0, read_addr}, k);
      check_eq("ramp_valid", {31'd0, valid}, (k >= 2) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Drain: en drops with one sample held and one read pending
    en = 1'b0;
    base = xfers;
    next_cycle();
    check_eq("drain_busy_last", {31'd0, busy}, 32'd1);
    next_cycle();
    check_eq("drain_busy_fall", {31'd0, busy}, 32'd0);
    repeat (4) next_cycle();
    check_eq("drain_xfers", xfers - base, 32'd2);
    check_eq("drain_addr", {24'd0, read_addr}, 32'd20);
    check_eq("drain_wraps", dut_wraps, exp_wraps);

    // Wrap: quarter-turn steps, carry on the 4th and 8th issues only
    pulse_clear();
    check_eq("clr_addr", {24'd0, read_addr}, 32'd0);
    step = 16'h4000;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("wrap_addr", {24'd0, read_addr}, (k * 64) % 256);
      check_eq("wrap_pulse", {31'd0, wrap}, (k == 4 || k == 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drain_check();

    // Backpressure after three transfers
    pulse_clear();
    step = PW'($urandom);
    en = 1'b1;
    ready = 1'b1;
    base = xfers;
    for (int i = 0; i < 20 && (xfers - base) < 3; i++) next_cycle();
    ready = 1'b0;
    check_eq("bp_xfers", xfers - base, 32'd3);
    addr_hold = read_addr;
    repeat (6) next_cycle();
    check_eq("bp_addr_frozen", {24'd0, read_addr}, {24'd0, addr_hold});
    check_eq("bp_valid", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("bp_no_gap", {31'd0, valid}, 32'd1);
      next_cycle();
    end

    // Random traffic with occasional clears and one asynchronous reset
    for (int k = 0; k < 400; k++) begin
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 49) == 0);
      if (k == 200) begin
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        check_eq("arst_addr", {24'd0, read_addr}, 32'd0);
        check_eq("arst_sample", {16'd0, sample}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_wrap", {31'd0, wrap}, 32'd0);
        next_cycle();
        rst = 1'b0;
      end else begin
        next_cycle();
      end
    end
    drain_check();

    // Clear with both entries full, then restart from address 0
    en = 1'b1;
    ready = 1'b0;
    repeat (5) next_cycle();
    check_eq("clr_full_valid", {31'd0, valid}, 32'd1);
    pulse_clear();
    check_eq("clr_valid", {31'd0, valid}, 32'd0);
    check_eq("clr_addr0", {24'd0, read_addr}, 32'd0);
    check_eq("clr_busy", {31'd0, busy}, 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 10 && !valid; i++) next_cycle();
    check_eq("clr_first", {15'd0, valid, sample}, {15'd0, 1'b1, lut[0]});
    repeat (10) next_cycle();
    drain_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
